// File: rtl/video_check_pkg.sv
// Shared types, constants and the CRC-32 step function for the video frame checker.
// The CRC path is only built when VIDEO_FRAME_CRC_EN is defined.
package video_check_pkg;

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam int          CRC_MAX_W = 64;

    localparam int ERR_LINE_LEN = 0;
    localparam int ERR_LINE_CNT = 1;
    localparam int ERR_DE_HREF  = 2;
    localparam int ERR_DE_VSYNC = 3;

    // Non-reflected CRC-32 over the low 'width' bits of data, MSB first
    function automatic logic [31:0] crc32_step(input logic [31:0]          crc,
                                               input logic [CRC_MAX_W-1:0] data,
                                               input int                   width);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                fb = c[31] ^ data[i];
                c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_crc32.sv
// DATA_WIDTH-parallel CRC-32 accumulator; crc_next already includes the current pixel
// so the owner can latch a frame result on the same cycle it restarts the register.
module video_crc32
    import video_check_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           crc_next
);

    logic [31:0]          crc_r;
    logic [31:0]          step_s;
    logic [CRC_MAX_W-1:0] data_ext_s;

    // Advance the CRC by one pixel
    always_comb begin
        data_ext_s                 = {CRC_MAX_W{1'b0}};
        data_ext_s[DATA_WIDTH-1:0] = data;
        step_s                     = crc32_step(crc_r, data_ext_s, DATA_WIDTH);
        if (en) begin
            crc_next = step_s;
        end else begin
            crc_next = crc_r;
        end
    end

    // Running CRC register, restarted at every frame start and while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= CRC_INIT;
        end else if (clear || init) begin
            crc_r <= CRC_INIT;
        end else if (en) begin
            crc_r <= step_s;
        end else begin
            crc_r <= crc_r;
        end
    end

endmodule

// File: rtl/video_frame_checker.sv
// Passive video geometry/sync monitor: per-frame line/pixel checks, frame and error counters.
// Define VIDEO_FRAME_CRC_EN to add a per-frame CRC-32 on frame_crc (tied to zero otherwise).
module video_frame_checker
    import video_check_pkg::*;
#(
    parameter int   IMG_HDISP  = 1280,
    parameter int   IMG_VDISP  = 720,
    parameter int   DATA_WIDTH = 24,
    parameter logic VS_POL     = 1'b1
) (
    input  logic                  video_clk,
    input  logic                  rst_n,
    input  logic                  video_vsync,
    input  logic                  video_href,
    input  logic                  video_de,
    input  logic [DATA_WIDTH-1:0] video_data,
    input  logic                  clr,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [3:0]            err_flags,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt,
    output logic [31:0]           frame_crc
);

    localparam logic [11:0] HDISP_C = 12'(IMG_HDISP);
    localparam logic [10:0] VDISP_C = 11'(IMG_VDISP);

    state_t      state_r;
    logic        vs_d_r;
    logic        de_d_r;
    logic [11:0] pix_cnt_r;
    logic [10:0] line_cnt_r;
    logic [3:0]  flags_r;

    logic        frame_done_r;
    logic        frame_ok_r;
    logic [3:0]  err_flags_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] err_cnt_r;

    logic        fs_s;
    logic        close_s;
    logic        line_end_s;
    logic [11:0] pix_inc_s;
    logic [11:0] pix_now_s;
    logic [10:0] line_now_s;
    logic [3:0]  flags_now_s;
    logic [3:0]  close_flags_s;

    // Frame view including this cycle's pixel; an open line is closed early at frame start
    always_comb begin
        if (VS_POL) begin
            fs_s = video_vsync & ~vs_d_r;
        end else begin
            fs_s = ~video_vsync & vs_d_r;
        end
        close_s = (state_r == S_FRAME) && fs_s;
        if (pix_cnt_r == 12'hFFF) begin
            pix_inc_s = pix_cnt_r;
        end else begin
            pix_inc_s = pix_cnt_r + 12'd1;
        end
        if (video_de) begin
            pix_now_s = pix_inc_s;
        end else begin
            pix_now_s = pix_cnt_r;
        end
        line_end_s = de_d_r & (~video_de | fs_s);
        if (line_end_s && (line_cnt_r != 11'h7FF)) begin
            line_now_s = line_cnt_r + 11'd1;
        end else begin
            line_now_s = line_cnt_r;
        end
        flags_now_s = flags_r;
        flags_now_s[ERR_LINE_LEN] = flags_r[ERR_LINE_LEN] | (line_end_s & (pix_now_s != HDISP_C));
        flags_now_s[ERR_DE_HREF]  = flags_r[ERR_DE_HREF] | (video_de & ~video_href);
        flags_now_s[ERR_DE_VSYNC] = flags_r[ERR_DE_VSYNC] | (video_de & (video_vsync == VS_POL));
        close_flags_s = flags_now_s;
        close_flags_s[ERR_LINE_CNT] = flags_now_s[ERR_LINE_CNT] | (line_now_s != VDISP_C);
    end

    // Sync tracking and working counters; every frame start restarts the measurement
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_SYNC;
            vs_d_r     <= 1'b0;
            de_d_r     <= 1'b0;
            pix_cnt_r  <= 12'd0;
            line_cnt_r <= 11'd0;
            flags_r    <= 4'd0;
        end else begin
            vs_d_r <= video_vsync;
            de_d_r <= video_de;
            if (fs_s) begin
                state_r    <= S_FRAME;
                pix_cnt_r  <= 12'd0;
                line_cnt_r <= 11'd0;
                flags_r    <= 4'd0;
            end else if (state_r == S_FRAME) begin
                pix_cnt_r  <= line_end_s ? 12'd0 : pix_now_s;
                line_cnt_r <= line_now_s;
                flags_r    <= flags_now_s;
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Frame results and status counters; clr overrides any increment
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
            frame_ok_r   <= 1'b0;
            err_flags_r  <= 4'd0;
            frame_cnt_r  <= 16'd0;
            err_cnt_r    <= 16'd0;
        end else begin
            frame_done_r <= close_s;
            if (close_s) begin
                frame_ok_r  <= ~|close_flags_s;
                err_flags_r <= close_flags_s;
            end
            if (clr) begin
                frame_cnt_r <= 16'd0;
                err_cnt_r   <= 16'd0;
            end else if (close_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                if ((|close_flags_s) && (err_cnt_r != 16'hFFFF)) begin
                    err_cnt_r <= err_cnt_r + 16'd1;
                end
            end
        end
    end

    assign frame_done = frame_done_r;
    assign frame_ok   = frame_ok_r;
    assign err_flags  = err_flags_r;
    assign frame_cnt  = frame_cnt_r;
    assign err_cnt    = err_cnt_r;

`ifdef VIDEO_FRAME_CRC_EN
    logic [31:0] crc_next_s;
    logic [31:0] frame_crc_r;

    video_crc32 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_crc (
        .clk     (video_clk),
        .rst_n   (rst_n),
        .init    (fs_s),
        .clear   (state_r == S_SYNC),
        .en      (video_de && (state_r == S_FRAME)),
        .data    (video_data),
        .crc_next(crc_next_s)
    );

    // Latch the finished frame's CRC, including a pixel on the closing cycle
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_crc_r <= 32'h0000_0000;
        end else if (close_s) begin
            frame_crc_r <= ~crc_next_s;
        end else begin
            frame_crc_r <= frame_crc_r;
        end
    end

    assign frame_crc = frame_crc_r;
`else
    logic unused_data_s;
    assign unused_data_s = ^video_data;
    assign frame_crc     = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed + randomized bench for video_frame_checker (8x4 frames, vsync active high).
// Expected results come from a frame-level description of what was driven.
module tb_video_frame_checker;

    localparam int          HD   = 8;
    localparam int          VD   = 4;
    localparam int          DW   = 24;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href  = 1'b0;
    logic          de    = 1'b0;
    logic          clr   = 1'b0;
    logic [DW-1:0] data  = {DW{1'b0}};

    logic          frame_done;
    logic          frame_ok;
    logic [3:0]    err_flags;
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;
    logic [31:0]   frame_crc;

    int            checks   = 0;
    int            failures = 0;

    bit            pend_valid = 1'b0;
    logic [3:0]    pend_flags = 4'd0;
    logic [31:0]   pend_crc   = 32'd0;
    logic [15:0]   m_frame_cnt = 16'd0;
    logic [15:0]   m_err_cnt   = 16'd0;
    bit            clr_at_fs   = 1'b0;

    always #5 clk = ~clk;

    video_frame_checker #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .DATA_WIDTH(DW),
        .VS_POL    (1'b1)
    ) dut (
        .video_clk  (clk),
        .rst_n      (rst_n),
        .video_vsync(vsync),
        .video_href (href),
        .video_de   (de),
        .video_data (data),
        .clr        (clr),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_flags  (err_flags),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .frame_crc  (frame_crc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [DW-1:0] px[$]);
        logic [31:0] c;
        logic        top;
        c = 32'hFFFF_FFFF;
        foreach (px[k]) begin
            for (int b = DW - 1; b >= 0; b--) begin
                top = c[31] ^ px[k][b];
                c   = c << 1;
                if (top) c = c ^ POLY;
            end
        end
        return ~c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic h, input logic e, input logic [DW-1:0] d);
        vsync = v;
        href  = h;
        de    = e;
        data  = d;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_ok"},   32'(frame_ok),   32'd0);
        chk({tag, "_err_flags"},  32'(err_flags),  32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        chk({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
        chk({tag, "_frame_crc"},  frame_crc,       32'd0);
    endtask

    // Called on the cycle after a frame start: compares the report for the frame just closed
    task automatic check_close(input bit cleared);
        if (pend_valid) begin
            if (cleared) begin
                m_frame_cnt = 16'd0;
                m_err_cnt   = 16'd0;
            end else begin
                m_frame_cnt = m_frame_cnt + 16'd1;
                if ((pend_flags != 4'd0) && (m_err_cnt != 16'hFFFF)) m_err_cnt = m_err_cnt + 16'd1;
            end
            chk("frame_done", 32'(frame_done), 32'd1);
            chk("err_flags",  32'(err_flags),  32'(pend_flags));
            chk("frame_ok",   32'(frame_ok),   32'(pend_flags == 4'd0));
            chk("frame_cnt",  32'(frame_cnt),  32'(m_frame_cnt));
            chk("err_cnt",    32'(err_cnt),    32'(m_err_cnt));
            chk("frame_crc",  frame_crc,       pend_crc);
        end else begin
            if (cleared) begin
                m_frame_cnt = 16'd0;
                m_err_cnt   = 16'd0;
            end
            chk("no_frame_done", 32'(frame_done), 32'd0);
            chk("idle_frame_cnt", 32'(frame_cnt), 32'(m_frame_cnt));
        end
    endtask

    // One frame: vsync pulse (closes the previous frame), nlines lines, trailing blank
    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input bit href_err, input bit vs_err, input bit zero);
        logic [DW-1:0] pix[$];
        logic [DW-1:0] d;
        logic [3:0]    f;
        bit            line_err;
        bit            cl;
        int            len;
        line_err = 1'b0;
        cl       = clr_at_fs;
        tick();
        drv(1'b1, 1'b0, 1'b0, {DW{1'b0}});
        clr = cl;
        tick();
        clr       = 1'b0;
        clr_at_fs = 1'b0;
        check_close(cl);
        for (int i = 0; i < 1 + $urandom_range(0, 2); i++) begin
            drv(1'b1, 1'b0, 1'b0, {DW{1'b0}});
            tick();
        end
        for (int l = 0; l < nlines; l++) begin
            if (!(vs_err && l == 0)) begin
                for (int g = 0; g < 1 + $urandom_range(0, 2); g++) begin
                    drv(1'b0, 1'b0, 1'b0, {DW{1'b0}});
                    tick();
                end
            end
            len = (l == bad_line) ? bad_len : HD;
            if (len != HD) line_err = 1'b1;
            for (int p = 0; p < len; p++) begin
                d = zero ? {DW{1'b0}} : DW'($urandom);
                drv(vs_err && l == 0 && p == 0, !(href_err && l == 0 && p == 0), 1'b1, d);
                pix.push_back(d);
                tick();
            end
        end
        for (int g = 0; g < 2 + $urandom_range(0, 2); g++) begin
            drv(1'b0, 1'b0, 1'b0, {DW{1'b0}});
            tick();
        end
        f          = {vs_err, href_err, nlines != VD, line_err};
        pend_valid = 1'b1;
        pend_flags = f;
`ifdef VIDEO_FRAME_CRC_EN
        pend_crc = ref_crc(pix);
`else
        pend_crc = 32'd0;
`endif
    endtask

    int nl;
    int bl;
    int blen;

    initial begin
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;

        repeat (3) send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        send_frame(VD, 1, 7, 1'b0, 1'b0, 1'b0);
        send_frame(VD + 1, -1, HD, 1'b0, 1'b0, 1'b0);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        send_frame(VD, -1, HD, 1'b1, 1'b1, 1'b0);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b1);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b1);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            nl   = $urandom_range(VD - 1, VD + 1);
            bl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
            blen = $urandom_range(1, 11);
            if (blen >= HD) blen++;
            send_frame(nl, bl, blen, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        force dut.err_cnt_r = 16'hFFFF;
        tick();
        release dut.err_cnt_r;
        m_err_cnt = 16'hFFFF;
        send_frame(VD, 0, 5, 1'b0, 1'b0, 1'b0);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        clr_at_fs = 1'b1;
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        rst_n      = 1'b1;
        pend_valid = 1'b0;
        m_frame_cnt = 16'd0;
        m_err_cnt   = 16'd0;
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);
        send_frame(VD, -1, HD, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
